imem_prog: RTL and testbench
============================

# imem_prog

Parametrised, run-time loadable instruction memory with a registered fetch port. It replaces the fixed combinational instruction ROM: the program is streamed in through a valid/ready load port, and the core then reads instructions with a one-cycle request/response fetch. The block sits between the boot/test loader and the core's fetch stage.

## Interface
Parameters:
- DATA_W, 8: instruction width in bits.
- ADDR_W, 8: fetch address width.
- DEPTH, 32: number of stored words. Must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle pulse that enters LOAD and clears the write pointer.
- load_valid  in  1  load word present on load_data.
- load_data  in  DATA_W  word to be written.
- load_last  in  1  marks the final word of the program (qualified by load_valid).
- load_ready  out  1  high while in LOAD.
- load_done  out  1  high while in RUN.
- fetch_req  in  1  fetch request, sampled every cycle.
- fetch_addr  in  ADDR_W  word address of the fetch.
- fetch_valid  out  1  response strobe, high for one cycle per request.
- instruction  out  DATA_W  fetched word, valid only when fetch_valid is high.
- fetch_err  out  1  qualifies fetch_valid; the response is NOP.
- parity_err  out  1  parity mismatch on the current response (only with IMEM_PROG_PARITY_EN).

## Operation
- States: IDLE, LOAD, RUN. Reset forces IDLE.
- Reset values: load_ready, load_done, fetch_valid, fetch_err and parity_err are 0; instruction is 0; the write pointer is 0.
- Reset never clears the storage array.
- IDLE:
  - load_start moves to LOAD.
  - Any other input is ignored except fetches, which are answered as described below.
- LOAD:
  - load_ready is 1.
  - Each cycle with load_valid && load_ready writes mem[wptr] = load_data, then wptr increments.
  - load_last on an accepted word, or acceptance of word DEPTH-1, moves to RUN on the next edge. wptr never wraps.
  - load_start in LOAD restarts at wptr = 0. Already written words stay until overwritten.
- RUN:
  - load_done is 1.
  - load_start returns to LOAD with wptr = 0.
  - Storage is read-only while in RUN.
- Fetch response:
  - In RUN with fetch_addr < DEPTH: instruction = mem[fetch_addr], fetch_err = 0.
  - In RUN with fetch_addr >= DEPTH, or in IDLE or LOAD: instruction = NOP (all zeros), fetch_err = 1.
- Simultaneous events:
  - load_start and fetch_req in the same RUN cycle: the fetch is served from the current contents with fetch_err = 0. The state then moves to LOAD.
  - A write and a fetch never collide, because writes occur only in LOAD.

## Timing
- Fetch latency is 1 cycle. A request sampled at edge N gives fetch_valid, instruction and fetch_err after edge N, held for exactly one cycle.
- Back-to-back fetches run at one per cycle with no bubbles. fetch_valid is deasserted the cycle after a cycle without fetch_req.
- Load throughput is one word per cycle.
- load_ready rises the cycle after the load_start edge.
- load_done rises the cycle after the edge that accepts the last word.
- Reset asserted mid-operation clears outputs immediately (asynchronously) and returns the state to IDLE. Partially loaded words remain in the array, and load_done stays 0 until a full load completes.

## Configuration
- IMEM_PROG_PARITY_EN defined:
  - Each stored word carries an extra even-parity bit, computed on write.
  - Parity is checked on every non-error fetch response.
  - On a mismatch, parity_err pulses together with fetch_valid. The instruction is still delivered unchanged.
- IMEM_PROG_PARITY_EN undefined:
  - No parity storage.
  - The parity_err port is absent.

## Structure
- Shared package imem_pkg contains:
  - the state enum (IDLE, LOAD, RUN);
  - the NOP constant (all zeros of DATA_W);
  - default parameter constants.
- Sub-module imem_prog_array holds the storage: synchronous write, registered read, and the optional parity bit.
- The top-level module holds the FSM, the write pointer and the fetch response logic.

## Test plan
- Load 12 words 0x45, 0x59, 0x18, 0x5C, 0x0D, 0xB4, 0x60, 0x1B, 0x8C, 0x48, 0x2C, 0xC3 with load_last on the 12th -> load_done = 1 one cycle later. Fetch addr 5 -> instruction 0xB4 with fetch_valid one cycle after the request, fetch_err = 0.
- Back-to-back fetches of addr 0, 1, 11 in consecutive cycles -> 0x45, 0x59, 0xC3 on three consecutive cycles, with no gaps.
- Fetch addr 40 (DEPTH 32) in RUN -> instruction 0x00, fetch_err = 1. Fetch addr 3 while in LOAD -> 0x00, fetch_err = 1.
- Stream 32 words without load_last -> automatic RUN after word 31. A 33rd load_valid is ignored (load_ready = 0) and mem[0] is unchanged.
- Assert rst_n low after 3 accepted words -> outputs go to their reset values immediately and the state is IDLE. load_start followed by a reload of 12 words -> normal fetches.
- With IMEM_PROG_PARITY_EN: flip one data bit of entry 2 by backdoor, then fetch addr 2 -> parity_err = 1 with fetch_valid. Fetch addr 3 -> parity_err = 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, NOP word, default parameter values and a
// helper to size storage indices.
package imem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 32;

  // NOP is all zeros; held wide so any DATA_W can take a slice of it.
  localparam int                    MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] NOP_WORD   = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Storage index width; at least one bit so a depth-1 array still has an index.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_prog_array.sv
// Instruction storage: synchronous write port, registered read port.
// Latency: read data (and parity flag) one cycle after re.
// Backpressure: none; one write and one read accepted every cycle.
//
// Ports: clk, rst_n; we/waddr/wdata write port; re/raddr read request;
// rdata registered read data (NOP when re was low); parity_err only with
// IMEM_PROG_PARITY_EN (stored even-parity bit disagrees with read word).
module imem_prog_array
  import imem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = idx_w(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
`ifdef IMEM_PROG_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  // Storage is deliberately not reset: a reset must not erase a program.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is reset so the fetch port comes out of reset as NOP;
  // a cycle without a valid read also loads NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= re ? mem[raddr] : NOP_WORD[DATA_W-1:0];
  end

`ifdef IMEM_PROG_PARITY_EN
  // Even parity: data bits plus parity bit hold an even number of ones.
  logic mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_par[waddr] <= ^wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= re && ((^mem[raddr]) != mem_par[raddr]);
  end
`endif

endmodule

// File: rtl/imem_prog.sv
// Run-time loadable instruction memory with a registered fetch port.
// Latency: fetch response one cycle after fetch_req; one fetch per cycle.
// Backpressure: load_ready high only in LOAD; fetch port never stalls.
//
// Ports: clk, rst_n (async, active low); load_start/load_valid/load_data/
// load_last/load_ready/load_done program load side; fetch_req/fetch_addr
// request and fetch_valid/instruction/fetch_err response. parity_err exists
// only when IMEM_PROG_PARITY_EN is defined. Requires DEPTH <= 2**ADDR_W.
module imem_prog
  import imem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              fetch_err
`ifdef IMEM_PROG_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int IDX_W = idx_w(DEPTH);
  // One spare bit: wptr steps to DEPTH after the final word and never wraps.
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t           state;
  logic [PTR_W-1:0] wptr;

  logic in_range;
  logic rd_en;
  logic wr_en;

  assign in_range = {1'b0, fetch_addr} < DEPTH_LIM;
  // Only RUN serves real data; the state sampled here is the pre-edge state,
  // so a fetch coinciding with load_start in RUN still reads the old program.
  assign rd_en    = fetch_req && (state == RUN) && in_range;
  // load_start wins over a word offered in the same cycle: the restart
  // drops that word rather than writing it at the old pointer.
  assign wr_en    = load_valid && load_ready && !load_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wptr        <= '0;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_valid <= fetch_req;
      fetch_err   <= fetch_req && !rd_en;

      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            wptr       <= '0;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            wptr <= '0;
          end else if (load_valid) begin
            wptr <= wptr + 1'b1;
            if (load_last || (wptr == LAST_PTR)) begin
              state      <= RUN;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            wptr       <= '0;
            load_ready <= 1'b1;
            load_done  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          load_ready <= 1'b0;
          load_done  <= 1'b0;
        end
      endcase
    end
  end

  // Array read register yields NOP for error responses, so instruction is
  // driven straight from it.
  imem_prog_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (wr_en),
    .waddr      (wptr[IDX_W-1:0]),
    .wdata      (load_data),
    .re         (rd_en),
    .raddr      (fetch_addr[IDX_W-1:0]),
    .rdata      (instruction)
`ifdef IMEM_PROG_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog: directed load/fetch vectors with a fetch scoreboard.
// Latency: expects every fetch response exactly one cycle after its request.
// Backpressure: load side driven only while load_ready is expected high.
module tb_imem_prog;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] instruction;
  logic              fetch_err;
`ifdef IMEM_PROG_PARITY_EN
  logic              parity_err;
`endif

  always #5 clk = ~clk;

  imem_prog #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .instruction (instruction),
    .fetch_err   (fetch_err)
`ifdef IMEM_PROG_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] instr;
    logic              err;
    logic              par;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [DATA_W-1:0] prog [12] = '{8'h45, 8'h59, 8'h18, 8'h5C, 8'h0D, 8'hB4,
                                   8'h60, 8'h1B, 8'h8C, 8'h48, 8'h2C, 8'hC3};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ins,
                            input logic e, input logic p);
    exp_t x;
    fetch_req  = 1'b1;
    fetch_addr = a;
    x.instr    = ins;
    x.err      = e;
    x.par      = p;
    x.cyc      = cyc + 1;
    sb.push_back(x);
  endtask

  task automatic fetch1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ins,
                        input logic e, input logic p);
    push_fetch(a, ins, e, p);
    step();
    fetch_req = 1'b0;
  endtask

  // Monitor: pops one expectation per response, and flags responses that
  // arrive unrequested or fail to arrive in their cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fetch_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch_valid: got instruction 0x%0h, expected no response", instruction);
        end else begin
          mon_e = sb.pop_front();
          chk("fetch_cycle", cyc, mon_e.cyc);
          chk("fetch_instr", instruction, mon_e.instr);
          chk("fetch_err", fetch_err, mon_e.err);
`ifdef IMEM_PROG_PARITY_EN
          chk("parity_err", parity_err, mon_e.par);
`endif
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_fetch_valid: got fetch_valid 0, expected response in cycle %0d", mon_e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    #3;
    chk("rst_load_ready", load_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_err", fetch_err, 0);
    chk("rst_instruction", instruction, 0);
    #9 rst_n = 1'b1;
    step();
    chk("idle_load_ready", load_ready, 0);
    fetch1(8'd0, 8'h00, 1'b1, 1'b0);

    // Program load of 12 words, with a fetch issued mid-load.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_ready_rise", load_ready, 1);
    chk("load_done_low", load_done, 0);
    for (int i = 0; i < 12; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = (i == 11);
      if (i == 4) push_fetch(8'd3, 8'h00, 1'b1, 1'b0);
      step();
      fetch_req = 1'b0;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("load_done_rise", load_done, 1);
    chk("load_ready_fall", load_ready, 0);

    fetch1(8'd5, 8'hB4, 1'b0, 1'b0);
    push_fetch(8'd0, 8'h45, 1'b0, 1'b0);
    step();
    push_fetch(8'd1, 8'h59, 1'b0, 1'b0);
    step();
    push_fetch(8'd11, 8'hC3, 1'b0, 1'b0);
    step();
    fetch_req = 1'b0;
    fetch1(8'd40, 8'h00, 1'b1, 1'b0);

    // Full-depth stream with no load_last: word i = i*7+3.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i * 7 + 3);
      step();
    end
    load_data = 8'hFF;
    chk("full_load_done", load_done, 1);
    chk("extra_word_not_ready", load_ready, 0);
    step();
    load_valid = 1'b0;
    fetch1(8'd0, 8'h03, 1'b0, 1'b0);
    fetch1(8'd31, 8'hDC, 1'b0, 1'b0);
    fetch1(8'd32, 8'h00, 1'b1, 1'b0);

    // load_start and fetch together in RUN: old contents served, then LOAD.
    load_start = 1'b1;
    push_fetch(8'd1, 8'h0A, 1'b0, 1'b0);
    step();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    chk("restart_load_ready", load_ready, 1);
    chk("restart_load_done", load_done, 0);

    // Reset after 3 accepted words.
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(8'hA0 + i);
      step();
    end
    load_valid = 1'b0;
    chk("preset_load_ready", load_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_load_ready", load_ready, 0);
    chk("async_rst_load_done", load_done, 0);
    chk("async_rst_fetch_valid", fetch_valid, 0);
    chk("async_rst_instruction", instruction, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_load_ready", load_ready, 0);
    chk("post_rst_load_done", load_done, 0);
    fetch1(8'd0, 8'h00, 1'b1, 1'b0);

    // Reload 12 words; entry 12 keeps its value from the full-depth stream.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = (i == 11);
      step();
      if (i == 6) chk("reload_done_low", load_done, 0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("reload_done", load_done, 1);
    fetch1(8'd0, 8'h45, 1'b0, 1'b0);
    fetch1(8'd5, 8'hB4, 1'b0, 1'b0);
    fetch1(8'd11, 8'hC3, 1'b0, 1'b0);
    fetch1(8'd12, 8'h57, 1'b0, 1'b0);

`ifdef IMEM_PROG_PARITY_EN
    dut.u_array.mem[2] = dut.u_array.mem[2] ^ 8'h01;
    fetch1(8'd2, 8'h19, 1'b0, 1'b1);
    fetch1(8'd3, 8'h5C, 1'b0, 1'b0);
`else
    fetch1(8'd2, 8'h18, 1'b0, 1'b0);
    fetch1(8'd3, 8'h5C, 1'b0, 1'b0);
`endif

    step();
    step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
